aa_stream: RTL and testbench
============================

Name: aa_stream

Overview:
- Streaming, parametrised successor to the frame-array anti-aliasing filter.
- Accepts a raster-order pixel stream with valid/ready and buffers two lines internally.
- Replaces each bright edge pixel with a rounded cross-neighbourhood average (selectable 4- or 5-tap); all other pixels pass through unchanged.
- Sits between the frame source and frame sink; pulses done once the whole frame has been emitted.

Parameters:
- PIX_W, 8, pixel width in bits.
- IMG_W, 640, pixels per line (≥3).
- IMG_H, 480, lines per frame (≥3).
- MODE, 1: 0 = 4-neighbour average; 1 = 5-pixel average including the centre.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame; th is latched here
- th  in  PIX_W  edge threshold
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_pixel  in  PIX_W  input pixel, raster order
- out_valid  out  1  output pixel valid
- out_ready  in  1  sink accepts the output pixel
- out_pixel  out  PIX_W  filtered pixel, raster order
- out_last  out  1  high with the final pixel (IMG_H-1, IMG_W-1)
- done  out  1  one-cycle pulse, the cycle after the out_last handshake

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_pixel=0, out_last=0, done=0, state=IDLE, all counters=0. Line buffer contents are not cleared; they are don't-care.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is produced. The next frame requires a new start.
- States:
  - IDLE: start moves to FILL and latches th_q. A start seen in any other state is ignored.
  - FILL: accepts the first IMG_W+1 pixels and produces no output.
  - RUN: each accepted input emits the output for the pixel IMG_W+1 positions earlier.
  - FLUSH: entered after the IMG_W*IMG_H-th input is accepted. Generates IMG_W+1 internal zero bubbles with in_ready=0, each emitting one output.
  - After the last output handshake, the block returns to IDLE and pulses done.
- Latency: the output for pixel (r,c) appears 1 cycle after input (r+1,c+1) is accepted, or after the matching flush bubble.
- Handshake:
  - in_ready = (FILL or RUN) and not (out_valid and not out_ready).
  - A transfer occurs on valid and ready.
  - While out_valid is high and out_ready is low, out_pixel and out_last hold stable and the pipeline stalls fully.
  - One-deep output register; full throughput is 1 pixel/cycle.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) always pass through unchanged. All flush bubbles therefore only feed border neighbours.
- Edge condition: C > th_q and at least one of N, S, E, W < th_q. Comparisons are strict and unsigned; equality is not an edge.
- Arithmetic:
  - MODE 0: (N+S+E+W+2)>>2. The sum is PIX_W+2 bits wide.
  - MODE 1: ((C+N+S+E+W)*205 + 512)>>10, with a PIX_W+3 bit sum and a PIX_W+11 bit product. The result is clamped to 2^PIX_W-1.
  - Non-edge pixels: out_pixel = C.
- Counters:
  - in_row/in_col and out_row/out_col wrap the column at IMG_W-1.
  - out_last is asserted exactly when out_row=IMG_H-1 and out_col=IMG_W-1.
- Simultaneous events: an input accept and an output handshake in the same cycle are both honoured. When the IMG_W*IMG_H-th input is accepted in RUN, the block enters FLUSH on the next cycle.

Decomposition:
- Package aa_pkg holds:
  - aa_state_t enum (IDLE, FILL, RUN, FLUSH);
  - aa_mode_e (AVG4=0, AVG5=1);
  - constants DIV5_MUL=205, DIV5_SH=10, DIV5_RND=512.
- Sub-module aa_line_buf: parametrised (IMG_W, PIX_W) delay line with shift enable, instantiated twice to provide the rows above and below. The top level keeps a 3-tap register window per row.

Test Plan:
- IMG_W=IMG_H=5, all pixels 100, th=50 -> 25 outputs all 100; out_last on the 25th; done 1 cycle later; in_ready low during the 6 flush cycles.
- 5x5, all pixels 0 except (2,2)=200, th=100 -> MODE 1: (2,2)=40, all others 0. MODE 0: (2,2)=0.
- 5x5, (2,2)=100, neighbours 0, th=100 -> (2,2)=100 unchanged (equality is not an edge).
- 5x5 random pixels, out_ready held low 10 cycles mid-frame -> in_ready low while stalled; out_pixel stable; output stream matches the reference model with no loss or duplication.
- Reset pulsed during RUN, then start with a new frame -> no done for the aborted frame; the second frame output is correct.
- Border (0,2)=200 with neighbours 0, th=100 -> (0,2)=200 passes through.

Source files
------------

// File: rtl/aa_pkg.sv
// aa_pkg: shared types and constants for the streaming anti-aliasing filter
package aa_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} aa_state_t;
  typedef enum logic {AVG4 = 1'b0, AVG5 = 1'b1} aa_mode_e;
  localparam int DIV5_MUL = 205;
  localparam int DIV5_SH = 10;
  localparam int DIV5_RND = 512;
endpackage

// File: rtl/aa_line_buf.sv
// aa_line_buf: IMG_W-deep circular delay line, dout is the sample pushed IMG_W shifts ago
module aa_line_buf #(
  parameter int IMG_W = 640,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);
  localparam int AW = $clog2(IMG_W);
  logic [PIX_W-1:0] mem [IMG_W];
  logic [AW-1:0] ptr_q, ptr_d;
  assign dout = mem[ptr_q];
  always_comb ptr_d = !en ? ptr_q : (ptr_q == AW'(IMG_W - 1)) ? '0 : ptr_q + AW'(1);
  always_ff @(posedge clk) begin
    ptr_q <= reset ? '0 : ptr_d;
    if (en) mem[ptr_q] <= din;
  end
endmodule

// File: rtl/aa_stream.sv
// aa_stream: streaming cross-neighbourhood anti-aliasing filter with two internal line buffers
module aa_stream import aa_pkg::*; #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int MODE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PIX_W-1:0] th,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  output logic             done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 2);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;
  aa_state_t state_q, state_d;
  logic [PIX_W-1:0] th_q, th_d, out_pixel_q, out_pixel_d;
  logic [PIX_W-1:0] s_q, s_d, c_q, c_d, w_q, w_d, n_q, n_d;
  logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
  logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
  logic [FW-1:0] fl_q, fl_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, done_q, done_d;
  logic can_out, acc, bub, adv, prod, fin, in_eol, in_last, out_eol, out_end, border, is_edge;
  logic [PIX_W-1:0] newest, e_pix, nb_pix, avg;
  logic [PIX_W+1:0] sum4;
  logic [PIX_W+2:0] sum5;
  logic [PIX_W+10:0] mul5, q5;
  aa_line_buf #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_buf_a (
    .clk(clk), .reset(reset), .en(adv), .din(newest), .dout(e_pix)
  );
  aa_line_buf #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_buf_b (
    .clk(clk), .reset(reset), .en(adv), .din(e_pix), .dout(nb_pix)
  );
  // window: s=S, e_pix=E, c=C, w=W, n=N of the pixel IMG_W+1 samples behind the newest
  always_comb begin
    can_out = !out_valid_q || out_ready;
    in_ready = (state_q == FILL || state_q == RUN) && can_out;
    acc = in_valid && in_ready;
    bub = state_q == FLUSH && fl_q != FW'(IMG_W + 1) && can_out;
    adv = acc || bub;
    prod = adv && state_q != FILL;
    fin = state_q == FLUSH && fl_q == FW'(IMG_W + 1) && out_valid_q && out_ready;
    newest = bub ? '0 : in_pixel;
    in_eol = in_col_q == CW'(IMG_W - 1);
    in_last = in_eol && in_row_q == RW'(IMG_H - 1);
    out_eol = out_col_q == CW'(IMG_W - 1);
    out_end = out_eol && out_row_q == RW'(IMG_H - 1);
    border = out_row_q == '0 || out_row_q == RW'(IMG_H - 1) || out_col_q == '0 || out_eol;
    is_edge = c_q > th_q && (n_q < th_q || s_q < th_q || e_pix < th_q || w_q < th_q);
    sum4 = (PIX_W+2)'(n_q) + (PIX_W+2)'(s_q) + (PIX_W+2)'(e_pix) + (PIX_W+2)'(w_q) + (PIX_W+2)'(2);
    sum5 = (PIX_W+3)'(c_q) + (PIX_W+3)'(n_q) + (PIX_W+3)'(s_q) + (PIX_W+3)'(e_pix) + (PIX_W+3)'(w_q);
    mul5 = (PIX_W+11)'(sum5) * (PIX_W+11)'(DIV5_MUL) + (PIX_W+11)'(DIV5_RND);
    q5 = mul5 >> DIV5_SH;
    avg = MODE == int'(AVG4) ? PIX_W'(sum4 >> 2) : (q5 > (PIX_W+11)'(PIX_MAX)) ? PIX_MAX : q5[PIX_W-1:0];
    state_d = (state_q == IDLE && start) ? FILL
            : (acc && state_q == FILL && in_row_q == RW'(1) && in_col_q == '0) ? RUN
            : (acc && in_last) ? FLUSH
            : fin ? IDLE : state_q;
    th_d = (state_q == IDLE && start) ? th : th_q;
    in_col_d = acc ? (in_eol ? '0 : in_col_q + CW'(1)) : in_col_q;
    in_row_d = (acc && in_eol) ? (in_last ? '0 : in_row_q + RW'(1)) : in_row_q;
    out_col_d = prod ? (out_eol ? '0 : out_col_q + CW'(1)) : out_col_q;
    out_row_d = (prod && out_eol) ? (out_end ? '0 : out_row_q + RW'(1)) : out_row_q;
    fl_d = fin ? '0 : bub ? fl_q + FW'(1) : fl_q;
    out_valid_d = prod || (out_valid_q && !out_ready);
    out_pixel_d = prod ? ((is_edge && !border) ? avg : c_q) : out_pixel_q;
    out_last_d = prod ? out_end : out_last_q;
    done_d = fin;
    s_d = adv ? newest : s_q;
    c_d = adv ? e_pix : c_q;
    w_d = adv ? c_q : w_q;
    n_d = adv ? nb_pix : n_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      th_q <= '0;
      in_col_q <= '0;
      in_row_q <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      fl_q <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      th_q <= th_d;
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      fl_q <= fl_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_last_q <= out_last_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    s_q <= s_d;
    c_q <= c_d;
    w_q <= w_d;
    n_q <= n_d;
  end
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_last = out_last_q;
  assign done = done_q;
endmodule

// File: tb/tb_aa_stream.sv
// tb_aa_stream: directed 5x5 frames through AVG5 and AVG4 instances of aa_stream
module tb_aa_stream;
  localparam int W = 5, H = 5, N = 25;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, out_ready = 1;
  logic [7:0] th = 0, in_pixel = 0, out_pixel, out_pixel0;
  logic in_ready, out_valid, out_last, done, in_ready0, out_valid0, out_last0, done0;
  int n_vec = 0, n_err = 0;
  int img[N];
  int th_v;
  logic [7:0] got[N], got0[N];
  logic gl[N];
  int n_in, n_out, viol, done_cnt, done_cyc, last_hs, flush_cyc;
  always #5 clk = ~clk;
  aa_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .MODE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .th(th), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_last(out_last), .done(done)
  );
  aa_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .th(th), .in_valid(in_valid), .in_ready(in_ready0),
    .in_pixel(in_pixel), .out_valid(out_valid0), .out_ready(out_ready), .out_pixel(out_pixel0),
    .out_last(out_last0), .done(done0)
  );
  function automatic logic [7:0] ref_pix(input int r, input int c, input int m);
    int cc, n, s, e, w, v;
    cc = img[r*W+c];
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 8'(cc);
    n = img[(r-1)*W+c]; s = img[(r+1)*W+c]; e = img[r*W+c+1]; w = img[r*W+c-1];
    if (!(cc > th_v && (n < th_v || s < th_v || e < th_v || w < th_v))) return 8'(cc);
    if (m == 0) return 8'((n + s + e + w + 2) >> 2);
    v = ((cc + n + s + e + w) * 205 + 512) >> 10;
    return 8'(v > 255 ? 255 : v);
  endfunction
  task automatic run_frame(input int st, input int sl);
    int cyc;
    logic pv, pl;
    logic [7:0] pp;
    n_in = 0; n_out = 0; viol = 0; done_cnt = 0; done_cyc = -1; last_hs = -1; flush_cyc = 0;
    pv = 0; pl = 0; pp = 0; cyc = 0;
    for (int i = 0; i < N; i++) begin got[i] = 0; got0[i] = 0; gl[i] = 0; end
    @(negedge clk); start = 1; th = 8'(th_v);
    @(negedge clk); start = 0;
    while (cyc < 400 && !(done_cnt > 0 && cyc > done_cyc + 3)) begin
      in_valid = n_in < N;
      in_pixel = n_in < N ? 8'(img[n_in]) : 8'd0;
      out_ready = !(cyc >= st && cyc < st + sl);
      #1;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (n_in == N && !in_ready && done_cnt == 0) flush_cyc++;
      if (n_in == N && in_ready) viol++;
      if (out_valid && !out_ready && in_ready) viol++;
      if (pv && (!out_valid || out_pixel !== pp || out_last !== pl)) viol++;
      if (in_ready0 !== in_ready || out_valid0 !== out_valid || out_last0 !== out_last || done0 !== done) viol++;
      if (in_valid && in_ready) n_in++;
      if (out_valid && out_ready) begin
        if (n_out < N) begin got[n_out] = out_pixel; got0[n_out] = out_pixel0; gl[n_out] = out_last; end
        n_out++;
        last_hs = cyc;
      end
      pv = out_valid && !out_ready; pp = out_pixel; pl = out_last;
      cyc++;
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_pixel !== 8'd0) begin n_err++; $display("FAIL reset_out_pixel got %0d want 0", out_pixel); end
    n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b want 0", out_last); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
  endtask
  task automatic test_flat;
    for (int i = 0; i < N; i++) img[i] = 100;
    th_v = 50;
    run_frame(1000, 0);
    n_vec++; if (n_out !== N) begin n_err++; $display("FAIL flat_count got %0d want %0d", n_out, N); end
    for (int i = 0; i < N; i++) begin
      n_vec++; if (got[i] !== 8'd100) begin n_err++; $display("FAIL flat_pix[%0d] got %0d want 100", i, got[i]); end
      n_vec++; if (gl[i] !== 1'(i == N-1)) begin n_err++; $display("FAIL flat_last[%0d] got %b want %b", i, gl[i], i == N-1); end
    end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL flat_done_count got %0d want 1", done_cnt); end
    n_vec++; if (done_cyc !== last_hs + 1) begin n_err++; $display("FAIL flat_done_time got %0d want %0d", done_cyc, last_hs + 1); end
    n_vec++; if (flush_cyc < 6) begin n_err++; $display("FAIL flat_flush_ready_low got %0d want >=6", flush_cyc); end
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL flat_protocol got %0d want 0", viol); end
  endtask
  task automatic test_spike;
    for (int i = 0; i < N; i++) img[i] = 0;
    img[12] = 200;
    th_v = 100;
    run_frame(1000, 0);
    n_vec++; if (n_out !== N) begin n_err++; $display("FAIL spike_count got %0d want %0d", n_out, N); end
    for (int i = 0; i < N; i++) begin
      n_vec++; if (got[i] !== (i == 12 ? 8'd40 : 8'd0)) begin n_err++; $display("FAIL spike_avg5[%0d] got %0d want %0d", i, got[i], i == 12 ? 40 : 0); end
      n_vec++; if (got0[i] !== 8'd0) begin n_err++; $display("FAIL spike_avg4[%0d] got %0d want 0", i, got0[i]); end
    end
  endtask
  task automatic test_equal;
    for (int i = 0; i < N; i++) img[i] = 0;
    img[12] = 100;
    th_v = 100;
    run_frame(1000, 0);
    n_vec++; if (got[12] !== 8'd100) begin n_err++; $display("FAIL equal_avg5 got %0d want 100", got[12]); end
    n_vec++; if (got0[12] !== 8'd100) begin n_err++; $display("FAIL equal_avg4 got %0d want 100", got0[12]); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL equal_done got %0d want 1", done_cnt); end
  endtask
  task automatic test_border;
    for (int i = 0; i < N; i++) img[i] = 0;
    img[2] = 200;
    th_v = 100;
    run_frame(1000, 0);
    n_vec++; if (got[2] !== 8'd200) begin n_err++; $display("FAIL border_avg5 got %0d want 200", got[2]); end
    n_vec++; if (got0[2] !== 8'd200) begin n_err++; $display("FAIL border_avg4 got %0d want 200", got0[2]); end
    n_vec++; if (got[7] !== 8'd0) begin n_err++; $display("FAIL border_below got %0d want 0", got[7]); end
  endtask
  task automatic test_stall;
    for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
    img[12] = 250; img[7] = 10; img[6] = 240; img[1] = 5;
    th_v = 128;
    run_frame(8, 10);
    n_vec++; if (n_out !== N) begin n_err++; $display("FAIL stall_count got %0d want %0d", n_out, N); end
    n_vec++; if (viol !== 0) begin n_err++; $display("FAIL stall_protocol got %0d want 0", viol); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL stall_done got %0d want 1", done_cnt); end
    for (int i = 0; i < N; i++) begin
      n_vec++; if (got[i] !== ref_pix(i / W, i % W, 1)) begin n_err++; $display("FAIL stall_avg5[%0d] got %0d want %0d", i, got[i], ref_pix(i / W, i % W, 1)); end
      n_vec++; if (got0[i] !== ref_pix(i / W, i % W, 0)) begin n_err++; $display("FAIL stall_avg4[%0d] got %0d want %0d", i, got0[i], ref_pix(i / W, i % W, 0)); end
    end
  endtask
  task automatic test_abort;
    int dn;
    for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
    img[17] = 255; img[16] = 0;
    th_v = 90;
    @(negedge clk); start = 1; th = 8'(th_v);
    @(negedge clk); start = 0; in_valid = 1;
    for (int i = 0; i < 12; i++) begin in_pixel = 8'(img[i]); @(negedge clk); end
    in_valid = 0; reset = 1;
    @(negedge clk); reset = 0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_ready got %b want 0", in_ready); end
    n_vec++; if (out_pixel !== 8'd0) begin n_err++; $display("FAIL abort_out_pixel got %0d want 0", out_pixel); end
    dn = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); #1; if (done || done0) dn++; end
    n_vec++; if (dn !== 0) begin n_err++; $display("FAIL abort_no_done got %0d want 0", dn); end
    run_frame(1000, 0);
    n_vec++; if (n_out !== N) begin n_err++; $display("FAIL abort_count got %0d want %0d", n_out, N); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL abort_done got %0d want 1", done_cnt); end
    for (int i = 0; i < N; i++) begin
      n_vec++; if (got[i] !== ref_pix(i / W, i % W, 1)) begin n_err++; $display("FAIL abort_avg5[%0d] got %0d want %0d", i, got[i], ref_pix(i / W, i % W, 1)); end
    end
  endtask
  initial begin
    test_reset;
    test_flat;
    test_spike;
    test_equal;
    test_border;
    test_stall;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
